// File: rtl/vga_timing_gen_if.sv
// VGA bus between the timing generator and the draw chain.
// The "out" modport is the source end; the "in" modport is a consumer.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing generator. The defaults give 1024x768@60 Hz at 65 MHz.
// hcount/vcount and every flag are registered together, with no skew between them.
// The flags are decoded from the next-state counter values.
// frame_start pulses on the cycle that shows (0,0) after a wrap, and frame_cnt counts those pulses.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk65MHz,
  input  logic        rst,
  vga_if.out          vga_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  // All compare constants are 11 bits wide, matching the counters.
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        h_last, v_last;

  // Next counter position, with flags decoded from it so they line up with the counters.
  always_comb begin
    h_last   = (hcount_q == H_LAST);
    v_last   = (vcount_q == V_LAST);
    hcount_d = h_last ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_last) begin
      vcount_d = v_last ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_d       = (hcount_d >= H_BLNK_BEG);
    vblnk_d       = (vcount_d >= V_BLNK_BEG);
    hsync_d       = ((hcount_d >= H_SYNC_BEG) && (hcount_d <= H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((vcount_d >= V_SYNC_BEG) && (vcount_d <= V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (hcount_d == 11'd0) && (vcount_d == 11'd0);
    frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
    // Reset parks at (0,0) with flags idle. The first free-running cycle then shows hcount=1,
    // so the reset position never produces a frame_start.
    if (rst) begin
      hcount_d      = 11'd0;
      vcount_d      = 11'd0;
      hblnk_d       = 1'b0;
      vblnk_d       = 1'b0;
      hsync_d       = ~SYNC_POL;
      vsync_d       = ~SYNC_POL;
      frame_start_d = 1'b0;
      frame_cnt_d   = 16'd0;
    end
  end

  // Register every output. Reset is already folded into the _d values, so it is synchronous.
  always_ff @(posedge clk65MHz) begin
    hcount_q      <= hcount_d;
    vcount_q      <= vcount_d;
    hsync_q       <= hsync_d;
    vsync_q       <= vsync_d;
    hblnk_q       <= hblnk_d;
    vblnk_q       <= vblnk_d;
    frame_start_q <= frame_start_d;
    frame_cnt_q   <= frame_cnt_d;
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  // Colour is owned by the downstream drawers.
  assign vga_out.rgb    = 12'h000;
  assign frame_start    = frame_start_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// dut_b uses the full 1024x768 timing and covers reset, line wrap, the horizontal window and
// mid-frame reset.
// A full-size frame is over a million clocks, so dut_s uses a scaled timing to cover the
// vertical window, the frame wrap and the frame period.
// dut_s timing: H_TOTAL = 16+2+4+6 = 28 and V_TOTAL = 8+1+2+3 = 14, so one frame is 392 clocks.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        rst_s = 1'b1;
  logic        fs_b, fs_s;
  logic [15:0] fc_b, fc_s;

  vga_if vif_b ();
  vga_if vif_s ();

  vga_timing_gen dut_b (
    .clk65MHz    (clk),
    .rst         (rst_b),
    .vga_out     (vif_b),
    .frame_start (fs_b),
    .frame_cnt   (fc_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(6),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1)
  ) dut_s (
    .clk65MHz    (clk),
    .rst         (rst_s),
    .vga_out     (vif_s),
    .frame_start (fs_s),
    .frame_cnt   (fc_s)
  );

  // clock: about 65 MHz
  always #7.5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hb_cnt, hb_first, hs_cnt, hs_first, hs_last;
  int vb_cnt, vb_first, vs_cnt, vs_first, vs_last, fs_cnt, n;

  initial begin
    // ---- 1. reset, full-size instance (dut_s also held in reset) ----
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        check("rst_hcount", vif_b.hcount, 0);
        check("rst_vcount", vif_b.vcount, 0);
        check("rst_hsync",  vif_b.hsync, 0);
        check("rst_vsync",  vif_b.vsync, 0);
        check("rst_hblnk",  vif_b.hblnk, 0);
        check("rst_vblnk",  vif_b.vblnk, 0);
        check("rst_rgb",    vif_b.rgb, 0);
        check("rst_fs",     fs_b, 0);
        check("rst_fc",     fc_b, 0);
      end
    end
    rst_b = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("post_rst_hcount", vif_b.hcount, i);
      check("post_rst_vcount", vif_b.vcount, 0);
    end

    // ---- 2. line wrap at (1343,10): t = 10*1344+1343 = 14783 ----
    step(14780);
    check("lw_hcount", vif_b.hcount, 1343);
    check("lw_vcount", vif_b.vcount, 10);
    check("lw_hblnk",  vif_b.hblnk, 1);
    step(1);
    check("lw_next_hcount", vif_b.hcount, 0);
    check("lw_next_vcount", vif_b.vcount, 11);
    check("lw_next_fs",     fs_b, 0);
    check("lw_next_hblnk",  vif_b.hblnk, 0);

    // ---- 3. horizontal window over line 11 ----
    hb_cnt = 0; hb_first = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 1344; i++) begin
      if (vif_b.hblnk) begin
        hb_cnt++;
        if (hb_first < 0) hb_first = int'(vif_b.hcount);
      end
      if (vif_b.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vif_b.hcount);
        hs_last = int'(vif_b.hcount);
      end
      step(1);
    end
    check("hblnk_len",   hb_cnt, 320);
    check("hblnk_rise",  hb_first, 1024);
    check("hsync_len",   hs_cnt, 136);
    check("hsync_first", hs_first, 1048);
    check("hsync_last",  hs_last, 1183);
    check("line12_hcount", vif_b.hcount, 0);
    check("line12_vcount", vif_b.vcount, 12);
    check("hblnk_fall",    vif_b.hblnk, 0);

    // ---- 6a. mid-frame reset on the full-size instance at (500,12) ----
    step(500);
    check("mid_pre_hcount", vif_b.hcount, 500);
    rst_b = 1'b1;
    step(1);
    check("mid_rst_hcount", vif_b.hcount, 0);
    check("mid_rst_vcount", vif_b.vcount, 0);
    check("mid_rst_fs",     fs_b, 0);
    check("mid_rst_fc",     fc_b, 0);
    rst_b = 1'b0;
    step(1);
    check("mid_resume_hcount", vif_b.hcount, 1);
    check("mid_resume_vcount", vif_b.vcount, 0);

    // ---- scaled instance: reset, then one full frame ----
    check("s_rst_hcount", vif_s.hcount, 0);
    check("s_rst_vsync",  vif_s.vsync, 0);
    check("s_rst_fc",     fc_s, 0);
    rst_s = 1'b0;
    step(1);
    check("s_post_rst_hcount", vif_s.hcount, 1);
    vb_cnt = 0; vb_first = -1; vs_cnt = 0; vs_first = -1; vs_last = -1;
    hs_cnt = 0; hs_first = -1; hs_last = -1; hb_cnt = 0; hb_first = -1; fs_cnt = 0;
    for (int t = 1; t < 392; t++) begin
      if (fs_s) fs_cnt++;
      if (vif_s.vblnk) begin
        vb_cnt++;
        if (vb_first < 0) vb_first = int'(vif_s.vcount);
      end
      if (vif_s.vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(vif_s.vcount);
        vs_last = int'(vif_s.vcount);
      end
      if (vif_s.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(vif_s.hcount);
        hs_last = int'(vif_s.hcount);
      end
      if (vif_s.hblnk) begin
        hb_cnt++;
        if (hb_first < 0) hb_first = int'(vif_s.hcount);
      end
      step(1);
    end
    // ---- 4. vertical window ----
    check("s_fs_inside_frame", fs_cnt, 0);
    check("s_vblnk_len",   vb_cnt, 168);
    check("s_vblnk_first", vb_first, 8);
    check("s_vsync_len",   vs_cnt, 56);
    check("s_vsync_first", vs_first, 9);
    check("s_vsync_last",  vs_last, 10);
    check("s_hsync_len",   hs_cnt, 56);
    check("s_hsync_first", hs_first, 18);
    check("s_hsync_last",  hs_last, 21);
    check("s_hblnk_len",   hb_cnt, 168);
    check("s_hblnk_first", hb_first, 16);
    // ---- 5. frame wrap and frame period ----
    check("s_wrap_hcount", vif_s.hcount, 0);
    check("s_wrap_vcount", vif_s.vcount, 0);
    check("s_wrap_fs",     fs_s, 1);
    check("s_wrap_fc",     fc_s, 1);
    check("s_wrap_vblnk",  vif_s.vblnk, 0);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!fs_s && n < 1000);
    check("s_frame_period", n, 392);
    check("s_fc_second",    fc_s, 2);
    step(1);
    check("s_fs_one_cycle", fs_s, 0);
    check("s_fc_hold",      fc_s, 2);

    // ---- 6b. mid-frame reset on the scaled instance at (10,5): t = 5*28+10 = 150 ----
    step(149);
    check("s_mid_pre_hcount", vif_s.hcount, 10);
    check("s_mid_pre_vcount", vif_s.vcount, 5);
    rst_s = 1'b1;
    step(1);
    check("s_mid_rst_hcount", vif_s.hcount, 0);
    check("s_mid_rst_vcount", vif_s.vcount, 0);
    check("s_mid_rst_fc",     fc_s, 0);
    check("s_mid_rst_fs",     fs_s, 0);
    rst_s = 1'b0;
    step(1);
    check("s_mid_resume_hcount", vif_s.hcount, 1);
    check("s_mid_resume_fs",     fs_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
